instr_fetch_unit: RTL
=====================

# instr_fetch_unit

Instruction/operand fetch stage that sits directly upstream of the matrix-multiply core's `control_unit`. It owns the program counter (PC) and issues reads to the instruction RAM (IRAM). It latches either the opcode byte into the instruction register (IR) or the following byte into the operand register (OR), and drives `instruction` and `status` into `control_unit`. It consumes the control unit's fetch, PC-increment, jump and end-of-process strobes.

## Interface
- `ADDR_W`, 8, IRAM address / PC width.
- `IRAM_LAT`, 1, IRAM read latency in clock edges; legal range 1..4.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse; leaves IDLE or HALT.
- `fetch_req`  in  1  fetch request (control unit `read_IRAM`).
- `fetch_sel`  in  1  0 = load IR (opcode), 1 = load OR (operand); sampled with `fetch_req`.
- `pc_inc`  in  1  PC += 1 (operand skip).
- `pc_load`  in  1  PC <= OR[ADDR_W-1:0] (taken jump).
- `halt`  in  1  control unit `end_process`.
- `iram_rd`  out  1  IRAM read strobe.
- `iram_addr`  out  ADDR_W  IRAM address.
- `iram_data`  in  8  IRAM read data.
- `instruction`  out  8  IR contents, to control unit.
- `operand`  out  8  OR contents.
- `ir_valid`  out  1  one-cycle pulse after any IR/OR capture.
- `status`  out  1  1 while the core is running (READY/REQ/WAIT states).
- `pc`  out  ADDR_W  current PC.
- `err`  out  1  sticky PC-overflow flag (see Configuration).

## Operation
- States: IDLE, READY, REQ, WAIT, HALT.
- IDLE: waits for `start`, then goes to READY with PC = 0.
- READY, on `fetch_req`: captures `fetch_sel`, goes to REQ.
- READY, `pc_inc` or `pc_load` without `fetch_req`: updates PC, stays in READY.
- READY, `fetch_req` together with `pc_load`/`pc_inc`: the PC update applies first, and REQ uses the new PC.
- REQ: exactly 1 cycle; `iram_rd = 1`, `iram_addr = pc`. Then goes to WAIT, and the wait counter is loaded with IRAM_LAT-1.
- WAIT: counts down. When the count reaches 0, on that edge:
  - captures `iram_data` into IR or OR according to the sampled `fetch_sel`;
  - PC <= PC + 1;
  - goes to READY and pulses `ir_valid`.
- `fetch_req`, `pc_inc` and `pc_load` are ignored in REQ and WAIT.
- `pc_load` beats `pc_inc` when both are asserted.
- `halt` in any state except IDLE: goes to HALT next edge and aborts any in-flight fetch. The fetch is not captured, and PC is unchanged.
- HALT: `iram_rd = 0`, `status = 0`. `start` returns to READY with PC = 0.
- `start` is ignored in READY, REQ and WAIT.
- PC arithmetic is unsigned, ADDR_W bits. Only OR[ADDR_W-1:0] is used for jumps.
- Reset (asynchronous, any state, including mid-fetch) sets: state = IDLE, `pc` = 0, IR = 0, OR = 0, `iram_rd` = 0, `iram_addr` = 0, `ir_valid` = 0, `status` = 0, `err` = 0.

## Timing
- `fetch_req` sampled at edge E0; `iram_rd` high from E0 to E1.
- IRAM samples the address at E1; data is valid IRAM_LAT-1 edges later.
- Capture happens at edge E(1+IRAM_LAT), and `ir_valid` is high for the following cycle.
- Fetch latency: IRAM_LAT+1 edges from request to capture. With the default IRAM_LAT = 1 this is 2 edges.
- Next `fetch_req` is accepted in the `ir_valid` cycle (back-to-back throughput: 1 fetch per IRAM_LAT+1 cycles).
- `status` is combinational from state; all other outputs are registered.

## Configuration
- `IFU_OVERFLOW_HALT_EN`, defined:
  - a PC increment from 2^ADDR_W-1 sets `err` = 1 (sticky until `rst`), leaves PC at 2^ADDR_W-1 and forces HALT;
  - a `pc_load` never sets `err`.
- Undefined: PC wraps to 0 silently, and `err` is tied to 0.

## Structure
- Package `ifu_pkg`: state enum `ifu_state_t`, `IFU_MAX_LAT = 4`, and opcode byte type `instr_t` (8 bits).
- Sub-module `ifu_pc_reg`: PC register with inc/load priority and overflow detection. The top level holds the FSM, wait counter, IR and OR.

## Test plan
- Reset, then `start`, then `fetch_req` with `fetch_sel = 0`, IRAM[0] = 8'h04 → `iram_rd` pulses with addr 0; `instruction` = 8'h04 and `ir_valid` = 1 two edges after the request; `pc` = 1.
- Opcode fetch, then operand fetch (`fetch_sel = 1`), IRAM[1] = 8'h10, then `pc_load` → `operand` = 8'h10, `pc` = 8'h10; the next fetch reads address 8'h10.
- `pc_inc` and `pc_load` together in READY → PC takes the load value; `fetch_req` while in WAIT is ignored (only one `iram_rd` pulse).
- `halt` during WAIT → no capture, `status` = 0, PC unchanged; `start` → PC = 0, `status` = 1.
- `rst` asserted asynchronously mid-REQ → all outputs 0 immediately, without waiting for an edge; state = IDLE.
- PC = 8'hFF, then a fetch completes → with `IFU_OVERFLOW_HALT_EN`: `err` = 1, HALT, PC = 8'hFF; without it: PC = 8'h00, `err` = 0. Repeat with IRAM_LAT = 3 and check capture 4 edges after the request.

Source files
------------

// File: rtl/ifu_pkg.sv
// ifu_pkg: shared types and limits for the instruction fetch unit.
package ifu_pkg;
   typedef enum logic [2:0] {S_IDLE, S_READY, S_REQ, S_WAIT, S_HALT} ifu_state_t;
   localparam int IFU_MAX_LAT = 4;
   localparam int CNT_W = $clog2(IFU_MAX_LAT);
   typedef logic [7:0] instr_t;
endpackage

// File: rtl/ifu_pc_reg.sv
// ifu_pc_reg: program counter with clear > load > inc priority.
// IFU_OVERFLOW_HALT_EN: an increment from all-ones is flagged and the PC holds.
module ifu_pc_reg #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr_i,
   input  logic              load_i,
   input  logic              inc_i,
   input  logic [ADDR_W-1:0] load_val_i,
   output logic [ADDR_W-1:0] pc_o,
   output logic              ovf_o
);
   logic [ADDR_W-1:0] pc_q, pc_d;
`ifdef IFU_OVERFLOW_HALT_EN
   assign ovf_o = inc_i & ~load_i & (&pc_q);
`else
   assign ovf_o = 1'b0;
`endif
   always_comb begin
      pc_d = pc_q;
      if (clr_i) pc_d = '0;
      else if (load_i) pc_d = load_val_i;
      else if (inc_i && !ovf_o) pc_d = pc_q + 1'b1;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) pc_q <= '0;
      else pc_q <= pc_d;
   assign pc_o = pc_q;
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC/IRAM fetch FSM loading IR or OR for the control unit.
// IFU_OVERFLOW_HALT_EN: PC overflow sets sticky err and forces HALT.
module instr_fetch_unit import ifu_pkg::*; #(
   parameter int ADDR_W   = 8,
   parameter int IRAM_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              fetch_req,
   input  logic              fetch_sel,
   input  logic              pc_inc,
   input  logic              pc_load,
   input  logic              halt,
   output logic              iram_rd,
   output logic [ADDR_W-1:0] iram_addr,
   input  logic [7:0]        iram_data,
   output instr_t            instruction,
   output logic [7:0]        operand,
   output logic              ir_valid,
   output logic              status,
   output logic [ADDR_W-1:0] pc,
   output logic              err
);
   ifu_state_t state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   instr_t ir_q, ir_d;
   logic [7:0] or_q, or_d;
   logic sel_q, sel_d, rd_q, rd_d, vld_q, vld_d, err_q, err_d;
   logic pc_clr, pc_inc_en, pc_load_en, ovf;

   ifu_pc_reg #(.ADDR_W(ADDR_W)) u_pc (
      .clk       (clk),
      .rst       (rst),
      .clr_i     (pc_clr),
      .load_i    (pc_load_en),
      .inc_i     (pc_inc_en),
      .load_val_i(or_q[ADDR_W-1:0]),
      .pc_o      (pc),
      .ovf_o     (ovf)
   );

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      ir_d       = ir_q;
      or_d       = or_q;
      sel_d      = sel_q;
      err_d      = err_q;
      rd_d       = 1'b0;
      vld_d      = 1'b0;
      pc_clr     = 1'b0;
      pc_inc_en  = 1'b0;
      pc_load_en = 1'b0;
      case (state_q)
         S_IDLE: if (start) begin
            state_d = S_READY;
            pc_clr  = 1'b1;
         end
         S_READY: if (halt) state_d = S_HALT;
         else begin
            // PC update lands on the same edge as the request, so REQ sees the new PC
            pc_load_en = pc_load;
            pc_inc_en  = pc_inc & ~pc_load;
            if (fetch_req) begin
               state_d = S_REQ;
               sel_d   = fetch_sel;
               rd_d    = 1'b1;
            end
         end
         S_REQ: begin
            state_d = halt ? S_HALT : S_WAIT;
            cnt_d   = CNT_W'(IRAM_LAT - 1);
         end
         S_WAIT: if (halt) state_d = S_HALT;
         else if (cnt_q == '0) begin
            ir_d      = sel_q ? ir_q : iram_data;
            or_d      = sel_q ? iram_data : or_q;
            pc_inc_en = 1'b1;
            vld_d     = 1'b1;
            state_d   = S_READY;
         end else cnt_d = cnt_q - 1'b1;
         S_HALT: if (!halt && start) begin
            state_d = S_READY;
            pc_clr  = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
      if (ovf) begin
         err_d   = 1'b1;
         rd_d    = 1'b0;
         state_d = S_HALT;
      end
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         ir_q    <= '0;
         or_q    <= '0;
         sel_q   <= 1'b0;
         rd_q    <= 1'b0;
         vld_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ir_q    <= ir_d;
         or_q    <= or_d;
         sel_q   <= sel_d;
         rd_q    <= rd_d;
         vld_q   <= vld_d;
         err_q   <= err_d;
      end

   assign iram_rd     = rd_q;
   assign iram_addr   = pc;
   assign instruction = ir_q;
   assign operand     = or_q;
   assign ir_valid    = vld_q;
   assign err         = err_q;
   assign status      = (state_q == S_READY) || (state_q == S_REQ) || (state_q == S_WAIT);
endmodule
